div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 15 +
 rtl/div_unit_step.sv | 27 ++
 rtl/div_unit.sv | 155 +++++++++++++++
 tb/tb_div_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: default width, counter width
// and the 2-bit state encoding used by the control FSM.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] diff_s;

    // Trial subtraction is WIDTH+1 bits wide so the borrow lands in the MSB.
    always_comb begin
        diff_s = {rem, dividend_bit} - {1'b0, divisor};
        if (diff_s[WIDTH] == 1'b0) begin
            next_rem = diff_s[WIDTH-1:0];
            q_bit    = 1'b1;
        end else begin
            next_rem = {rem[WIDTH-2:0], dividend_bit};
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider feeding HI/LO: one quotient bit per cycle,
// sign fix-up afterwards, quotient on lo_o, remainder on hi_o, one-cycle done.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic             annul,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    div_state_e       state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] qd_r;       // dividend shifts out the top, quotient in at the bottom
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] rem_r;
    logic             q_neg_r;
    logic             r_neg_r;
    logic             dbz_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH-1:0] abs_a_s;
    logic [WIDTH-1:0] abs_b_s;
    logic [WIDTH-1:0] step_rem_s;
    logic             step_q_s;

    // Operand magnitudes; 0x80..0 maps onto itself and is then read as unsigned.
    always_comb begin
        if (signed_op && opa[WIDTH-1]) begin
            abs_a_s = twos_neg(opa);
        end else begin
            abs_a_s = opa;
        end
        if (signed_op && opb[WIDTH-1]) begin
            abs_b_s = twos_neg(opb);
        end else begin
            abs_b_s = opb;
        end
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem_r),
        .divisor      (divisor_r),
        .dividend_bit (qd_r[WIDTH-1]),
        .next_rem     (step_rem_s),
        .q_bit        (step_q_s)
    );

    // Control FSM, datapath registers and committed HI/LO results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            qd_r      <= ZERO;
            divisor_r <= ZERO;
            rem_r     <= ZERO;
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            dbz_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= ZERO;
            lo_r      <= ZERO;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && !annul) begin
                        divisor_r <= abs_b_s;
                        rem_r     <= ZERO;
                        cnt_r     <= CNT_ZERO;
                        q_neg_r   <= signed_op & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        r_neg_r   <= signed_op & opa[WIDTH-1];
                        busy_r    <= 1'b1;
                        if (opb == ZERO) begin
                            // Keep the raw dividend: it becomes the remainder.
                            qd_r    <= opa;
                            dbz_r   <= 1'b1;
                            state_r <= ST_FIX;
                        end else begin
                            qd_r    <= abs_a_s;
                            dbz_r   <= 1'b0;
                            state_r <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (annul) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        rem_r <= step_rem_s;
                        qd_r  <= {qd_r[WIDTH-2:0], step_q_s};
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        if (cnt_r == CNT_LAST) begin
                            state_r <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    if (annul) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        if (dbz_r) begin
                            lo_r <= {WIDTH{1'b1}};
                            hi_r <= qd_r;
                        end else begin
                            lo_r <= q_neg_r ? twos_neg(qd_r) : qd_r;
                            hi_r <= r_neg_r ? twos_neg(rem_r) : rem_r;
                        end
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi_o = hi_r;
    assign lo_o = lo_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, abort/reset
// scenarios and random operands against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        signed_op;
    logic        annul;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_hi = 32'h0;
    logic [31:0] last_lo = 32'h0;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .signed_op (signed_op),
        .annul     (annul),
        .opa       (opa),
        .opb       (opb),
        .busy      (busy),
        .done      (done),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic (truncating division) so -2^31/-1 wraps naturally.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'h0, a});
                sb = longint'({32'h0, b});
            end
            lq = sa / sb;
            lr = sa % sb;
            q = lq[31:0];
            r = lr[31:0];
        end
    endtask

    // One complete operation; inputs change 1 time unit after the rising edge.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input bit noise, input string tag);
        logic [31:0] eq, er;
        int lat, bcnt;
        bit seen;
        ref_div(a, b, sgn, eq, er);
        opa = a; opb = b; signed_op = sgn; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_rise"}, {31'h0, busy}, 32'h1);
        lat = 0; bcnt = 1; seen = 0;
        while (!seen && lat < 60) begin
            if (noise && lat >= 3 && lat < 6) begin
                start = 1'b1; opa = $urandom; opb = $urandom; signed_op = ~sgn;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
            if (done) seen = 1;
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, (b == 32'h0) ? 32'd1 : 32'd33);
        check({tag, "_lo"}, lo_o, eq);
        check({tag, "_hi"}, hi_o, er);
        check({tag, "_busy_cycles"}, bcnt, (b == 32'h0) ? 32'd2 : 32'd34);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
        check({tag, "_busy_fall"}, {31'h0, busy}, 32'h0);
        last_hi = er;
        last_lo = eq;
    endtask

    initial begin
        int dcnt;
        logic [31:0] ra, rb;
        reset_n = 1'b0; start = 1'b0; signed_op = 1'b0; annul = 1'b0;
        opa = 32'h0; opb = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        run_div(32'd100, 32'd7, 1'b0, 0, "divu_100_7");
        check("divu_100_7_lo_const", lo_o, 32'd14);
        check("divu_100_7_hi_const", hi_o, 32'd2);
        run_div(32'hFFFF_FFF9, 32'h2, 1'b1, 0, "div_m7_2");
        check("div_m7_2_lo_const", lo_o, 32'hFFFF_FFFD);
        check("div_m7_2_hi_const", hi_o, 32'hFFFF_FFFF);
        run_div(32'h7, 32'hFFFF_FFFE, 1'b1, 0, "div_7_m2");
        check("div_7_m2_lo_const", lo_o, 32'hFFFF_FFFD);
        check("div_7_m2_hi_const", hi_o, 32'h1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "div_min_m1");
        check("div_min_m1_lo_const", lo_o, 32'h8000_0000);
        run_div(32'hFFFF_FFFF, 32'h1, 1'b0, 0, "divu_max_1");
        run_div(32'h0000_1234, 32'h0, 1'b1, 0, "div_by0");
        run_div(32'h0000_1234, 32'h0, 1'b0, 0, "divu_by0");
        check("divu_by0_hi_const", hi_o, 32'h0000_1234);

        // Abort mid-CALC with ignored start pulses: no done, results held.
        opa = 32'd1000; opb = 32'd3; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 10; i++) begin
            start = (i >= 3 && i <= 5) ? 1'b1 : 1'b0;
            opa = 32'd77; opb = 32'd5;
            @(posedge clk); #1;
        end
        start = 1'b0; annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        check("annul_busy", {31'h0, busy}, 32'h0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        check("annul_no_done", dcnt, 32'd0);
        check("annul_hi_held", hi_o, last_hi);
        check("annul_lo_held", lo_o, last_lo);

        // Start together with annul in IDLE is dropped.
        start = 1'b1; annul = 1'b1; opa = 32'd5; opb = 32'd1;
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        check("annul_start_idle", {31'h0, busy}, 32'h0);

        run_div(32'd9, 32'd3, 1'b0, 0, "divu_9_3");
        run_div(32'd12345, 32'd67, 1'b0, 1, "noise_start");

        // Asynchronous reset in the middle of CALC.
        opa = 32'd500; opb = 32'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_hi", hi_o, 32'h0);
        check("midrst_lo", lo_o, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        run_div(32'd10, 32'd3, 1'b0, 0, "divu_10_3");

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = rb >> $urandom_range(0, 31);
                1: ra = 32'h8000_0000;
                2: rb = 32'h0;
                default: ra = ra;
            endcase
            run_div(ra, rb, 1'($urandom_range(0, 1)), 1'(i % 3 == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
